// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder-side and data-memory signals of the pipeline hazard controller.
// slave is the controller itself; master is the pipeline/decoder side.
interface pipe_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_mem_write;
  logic       ex_jump_taken;
  logic       dmem_ack;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       pipe_freeze;
  logic       dmem_req;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       mem_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, ex_jump_taken, dmem_ack,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze,
           dmem_req, fwd_a, fwd_b, mem_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, ex_jump_taken, dmem_ack,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze,
           dmem_req, fwd_a, fwd_b, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing: load-use stalls, jump flushes, EX forwarding
// selects and a data-memory handshake that freezes the pipe while busy.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  ctl
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       wr;
    logic       ld;
    logic       st;
  } shadow_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  shadow_t            ex_q, ex_d;
  shadow_t            mem_q, mem_d;
  shadow_t            wb_q, wb_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               mem_access;
  logic               timeout;
  logic               freeze;
  logic               dmem_req_c;
  logic               mem_err_c;
  logic               load_use;
  logic               pc_write_c;
  logic               ifid_write_c;
  logic               ifid_flush_c;
  logic               idex_flush_c;
  logic [1:0]         fwd_a_c;
  logic [1:0]         fwd_b_c;

  // MEM result wins over WB; loads in MEM have no data yet, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input shadow_t m, input shadow_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs) begin
      if (m.v && m.wr && !m.ld && (m.rd != 5'd0) && (m.rd == rs))
        sel = 2'b10;
      else if (w.v && w.wr && (w.rd != 5'd0) && (w.rd == rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  // ---------------- shadow pipeline ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (idex_flush_c) begin
        ex_d = '0;
      end else begin
        ex_d.v    = ctl.id_valid;
        ex_d.rd   = ctl.id_rd;
        ex_d.rs1  = ctl.id_rs1;
        ex_d.rs2  = ctl.id_rs2;
        ex_d.use1 = ctl.id_use_rs1;
        ex_d.use2 = ctl.id_use_rs2;
        ex_d.wr   = ctl.id_reg_write;
        ex_d.ld   = ctl.id_mem_read;
        ex_d.st   = ctl.id_mem_write;
      end
    end
  end

  // WB only needs its destination info; the rest rides along for debug visibility.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rs1, wb_q.rs2, wb_q.use1, wb_q.use2, wb_q.ld, wb_q.st};

  // ---------------- memory handshake FSM ----------------
  assign mem_access = mem_q.v && (mem_q.ld || mem_q.st);
  assign timeout    = (state_q == S_WAIT) && !ctl.dmem_ack
                      && (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_access && !ctl.dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (ctl.dmem_ack || timeout) state_d = S_IDLE;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Freeze starts in the request cycle itself so the access never leaves MEM.
  always_comb begin
    dmem_req_c = 1'b0;
    freeze     = 1'b0;
    mem_err_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req_c = mem_access;
        freeze     = mem_access && !ctl.dmem_ack;
      end
      S_WAIT: begin
        dmem_req_c = 1'b1;
        freeze     = !ctl.dmem_ack && !timeout;
        mem_err_c  = timeout;
      end
      default: ;
    endcase
  end

  // ---------------- stall / flush / forwarding ----------------
  assign load_use = ex_q.v && ex_q.ld && (ex_q.rd != 5'd0) && ctl.id_valid
                    && ((ctl.id_use_rs1 && (ctl.id_rs1 == ex_q.rd))
                     || (ctl.id_use_rs2 && (ctl.id_rs2 == ex_q.rd)));

  always_comb begin
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    if (freeze) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
    end else if (ctl.ex_jump_taken) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (load_use) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      idex_flush_c = 1'b1;
    end
  end

  always_comb begin
    fwd_a_c = fwd_sel(ex_q.rs1, ex_q.use1, mem_q, wb_q);
    fwd_b_c = fwd_sel(ex_q.rs2, ex_q.use2, mem_q, wb_q);
  end

  assign ctl.pc_write    = pc_write_c;
  assign ctl.ifid_write  = ifid_write_c;
  assign ctl.ifid_flush  = ifid_flush_c;
  assign ctl.idex_flush  = idex_flush_c;
  assign ctl.pipe_freeze = freeze;
  assign ctl.dmem_req    = dmem_req_c;
  assign ctl.fwd_a       = fwd_a_c;
  assign ctl.fwd_b       = fwd_b_c;
  assign ctl.mem_err     = mem_err_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT overridden to 4).
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ld;
    logic       st;
  } id_t;

  typedef struct {
    string       nm;
    logic [10:0] e;
  } exp_t;

  // Expected word layout: {pc_write, ifid_write, ifid_flush, idex_flush,
  //                        pipe_freeze, dmem_req, fwd_a[1:0], fwd_b[1:0], mem_err}
  localparam logic [10:0] N   = 11'b1_1_0_0_0_0_00_00_0;
  localparam logic [10:0] STL = 11'b0_0_0_1_0_0_00_00_0;
  localparam logic [10:0] FRZ = 11'b0_0_0_0_1_1_00_00_0;
  localparam logic [10:0] REQ = 11'b1_1_0_0_0_1_00_00_0;
  localparam logic [10:0] JMP = 11'b1_1_1_1_0_0_00_00_0;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic id_t nop();
    return '0;
  endfunction

  function automatic id_t ins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic wr,
                              input logic ld, input logic st);
    id_t r;
    r.v = 1'b1; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.u1 = u1; r.u2 = u2; r.wr = wr; r.ld = ld; r.st = st;
    return r;
  endfunction

  task automatic step(input string nm, input logic rst, input id_t id,
                      input logic jmp, input logic ack, input logic [10:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    reset             = rst;
    bus.id_valid      = id.v;
    bus.id_rd         = id.rd;
    bus.id_rs1        = id.rs1;
    bus.id_rs2        = id.rs2;
    bus.id_use_rs1    = id.u1;
    bus.id_use_rs2    = id.u2;
    bus.id_reg_write  = id.wr;
    bus.id_mem_read   = id.ld;
    bus.id_mem_write  = id.st;
    bus.ex_jump_taken = jmp;
    bus.dmem_ack      = ack;
    x.nm = nm;
    x.e  = e;
    sb.push_back(x);
  endtask

  // Monitor: the controller presents a full output word every cycle.
  initial begin
    exp_t        x;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        act = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
               bus.pipe_freeze, bus.dmem_req, bus.fwd_a, bus.fwd_b, bus.mem_err};
        n_vec++;
        if (act !== x.e) begin
          n_bad++;
          $display("FAIL %s: got %b want %b (pc,ifid,ifl,idfl,frz,req,fa,fb,err)",
                   x.nm, act, x.e);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_reg_write = 1'b0;
    bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
    bus.ex_jump_taken = 1'b0; bus.dmem_ack = 1'b1;

    step("reset",       1, nop(), 0, 1, N);

    // load-use: lw x5 then add x6,x5,x7
    step("lu_lw",       0, ins(5, 1, 0, 1, 0, 1, 1, 0), 0, 1, N);
    step("lu_stall",    0, ins(6, 5, 7, 1, 1, 1, 0, 0), 0, 1, STL);
    step("lu_resume",   0, ins(6, 5, 7, 1, 1, 1, 0, 0), 0, 1, REQ);
    step("lu_fwd_wb",   0, nop(),                       0, 1, 11'b1_1_0_0_0_0_01_00_0);
    step("lu_drain",    0, nop(),                       0, 1, N);

    // EX/MEM forwarding: add x3 ; sub x4,x3,x3
    step("fm_add",      0, ins(3, 1, 2, 1, 1, 1, 0, 0), 0, 1, N);
    step("fm_sub",      0, ins(4, 3, 3, 1, 1, 1, 0, 0), 0, 1, N);
    step("fm_fwd_mem",  0, nop(),                       0, 1, 11'b1_1_0_0_0_0_10_10_0);
    step("fm_drain",    0, nop(),                       0, 1, N);

    // x0 destination never forwards (MEM and WB)
    step("x0_addi",     0, ins(0, 0, 0, 1, 0, 1, 0, 0), 0, 1, N);
    step("x0_add1",     0, ins(1, 0, 0, 1, 1, 1, 0, 0), 0, 1, N);
    step("x0_mem",      0, ins(2, 0, 0, 1, 1, 1, 0, 0), 0, 1, N);
    step("x0_wb",       0, nop(),                       0, 1, N);

    // MEM has priority over WB for the same register
    step("pr_a",        0, ins(9, 1, 1, 1, 1, 1, 0, 0), 0, 1, N);
    step("pr_b",        0, ins(9, 2, 2, 1, 1, 1, 0, 0), 0, 1, N);
    step("pr_or",       0, ins(10, 9, 2, 1, 1, 1, 0, 0), 0, 1, N);
    step("pr_mem_win",  0, nop(),                       0, 1, 11'b1_1_0_0_0_0_10_00_0);

    // jump in the same cycle as a load-use hazard
    step("jl_lw",       0, ins(12, 1, 0, 1, 0, 1, 1, 0), 0, 1, N);
    step("jl_jump",     0, ins(13, 12, 0, 1, 1, 1, 0, 0), 1, 1, JMP);
    step("jl_nostall",  0, nop(),                       0, 1, REQ);
    step("jl_drain",    0, nop(),                       0, 1, N);

    // store with ack 3 cycles late
    step("mw_sw",       0, ins(0, 1, 5, 1, 1, 0, 0, 1), 0, 1, N);
    step("mw_add",      0, ins(14, 1, 2, 1, 1, 1, 0, 0), 0, 1, N);
    step("mw_frz0",     0, ins(15, 14, 14, 1, 1, 1, 0, 0), 0, 0, FRZ);
    step("mw_frz1",     0, ins(15, 14, 14, 1, 1, 1, 0, 0), 0, 0, FRZ);
    step("mw_frz2",     0, ins(15, 14, 14, 1, 1, 1, 0, 0), 0, 0, FRZ);
    step("mw_ack",      0, ins(15, 14, 14, 1, 1, 1, 0, 0), 0, 1, REQ);
    step("mw_adv",      0, nop(),                       0, 1, 11'b1_1_0_0_0_0_10_10_0);
    step("mw_drain",    0, nop(),                       0, 1, N);

    // timeout with a jump held in EX across the freeze
    step("to_lw",       0, ins(16, 1, 0, 1, 0, 1, 1, 0), 0, 1, N);
    step("to_gap",      0, nop(),                       0, 1, N);
    step("to_req",      0, nop(),                       1, 0, FRZ);
    step("to_wait0",    0, nop(),                       1, 0, FRZ);
    step("to_wait1",    0, nop(),                       1, 0, FRZ);
    step("to_wait2",    0, nop(),                       1, 0, FRZ);
    step("to_wait3",    0, nop(),                       1, 0, FRZ);
    step("to_err",      0, nop(),                       1, 0, 11'b1_1_1_1_0_1_00_00_1);
    step("to_after",    0, nop(),                       0, 1, N);

    // reset while waiting
    step("rs_sw",       0, ins(0, 1, 2, 1, 1, 0, 0, 1), 0, 1, N);
    step("rs_gap",      0, nop(),                       0, 1, N);
    step("rs_req",      0, nop(),                       0, 0, FRZ);
    step("rs_assert",   1, nop(),                       0, 0, FRZ);
    step("rs_cleared",  0, nop(),                       0, 0, N);
    step("rs_idle",     0, nop(),                       0, 1, N);

    // load-use through rs2
    step("l2_lw",       0, ins(20, 1, 0, 1, 0, 1, 1, 0), 0, 1, N);
    step("l2_stall",    0, ins(21, 1, 20, 1, 1, 1, 0, 0), 0, 1, STL);
    step("l2_resume",   0, ins(21, 1, 20, 1, 1, 1, 0, 0), 0, 1, REQ);
    step("l2_fwd_wb",   0, nop(),                       0, 1, 11'b1_1_0_0_0_0_00_01_0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      n_bad += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
